dvp_capture_multi: RTL
======================

DVP_CAPTURE_MULTI -- requirements
Module: dvp_capture_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of camera channels.
REQ-002 SHALL have parameter DATA_W, default 8, camera bus width.
REQ-003 SHALL have parameter BPP, default 2, bytes per pixel; PIX_W = DATA_W*BPP.
REQ-004 SHALL have parameter H_ACTIVE, default 640, pixels per line.
REQ-005 SHALL have parameter V_ACTIVE, default 480, lines per frame.
REQ-006 SHALL have port clk, input, 1: sole clock, at least 4x the fastest vid_pclk.
REQ-007 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port enable, input, 1: capture enable.
REQ-009 SHALL have port frame_sync_en, input, 1: 1 makes all channels start capturing on the same frame.
REQ-010 SHALL have port err_clr, input, 1: single-cycle pulse that clears sticky flags.
REQ-011 SHALL have port vid_pclk, input, NUM_CH: raw camera pixel clocks, asynchronous to clk.
REQ-012 SHALL have port vid_data, input, NUM_CH*DATA_W: raw camera data; channel i occupies [i*DATA_W +: DATA_W].
REQ-013 SHALL have port vid_hsync, input, NUM_CH: line-valid (HREF), active-high, raw.
REQ-014 SHALL have port vid_vsync, input, NUM_CH: frame sync, active-high, raw.
REQ-015 SHALL have port m_tdata, output, NUM_CH*PIX_W: pixel data per channel.
REQ-016 SHALL have ports m_tvalid, m_tuser and m_tlast, output, NUM_CH each: valid, start-of-frame and end-of-line.
REQ-017 SHALL have port m_tready, input, NUM_CH: downstream ready.
REQ-018 SHALL have ports overflow, line_err and frame_err, output, NUM_CH each: sticky error flags.
REQ-019 SHALL have port frame_cnt, output, NUM_CH*8: completed-frame counters.

Function
REQ-020 SHALL pass vid_pclk, vid_hsync, vid_vsync and vid_data through two clk flops per channel, all on identical delay; pclk, hsync and vsync SHALL get a third flop for edge detection.
REQ-021 SHALL treat a sampled pclk 0->1 transition as a pixel-clock event; data and hsync used at that event SHALL be from the same synchronizer stage as the pclk sample.
REQ-022 SHALL give each channel an FSM with states DISABLED, WAIT_VS, ARMED and CAPTURE.
REQ-023 In DISABLED, enable=1 SHALL move the FSM to WAIT_VS.
REQ-024 In WAIT_VS, a vsync rising edge SHALL move the FSM to ARMED; partial frames SHALL never be captured.
REQ-025 In ARMED, a vsync falling edge SHALL set the channel's rdy flag.
REQ-026 With frame_sync_en=0, the FSM SHALL go from ARMED to CAPTURE on its own rdy flag.
REQ-027 With frame_sync_en=1, all channels SHALL enter CAPTURE in the same cycle once every rdy flag is set.
REQ-028 A vsync rising edge in ARMED SHALL clear that channel's rdy flag, which then waits for the next frame.
REQ-029 In WAIT_VS or ARMED, enable=0 SHALL move the FSM to DISABLED immediately.
REQ-030 In CAPTURE, enable=0 SHALL take effect only at the next vsync rising edge.
REQ-031 In CAPTURE, each pixel-clock event with hsync=1 SHALL shift one byte in, first byte into the MSBs; after BPP bytes, one pixel SHALL be complete.
REQ-032 A completed pixel SHALL set m_tuser=1 only for pixel 0 of line 0, and m_tlast=1 only for pixel H_ACTIVE-1.
REQ-033 Pixels beyond H_ACTIVE in a line SHALL be dropped and SHALL set line_err.
REQ-034 An hsync falling edge SHALL set line_err if the pixel count != H_ACTIVE or the byte phase != 0, then clear the pixel counter and byte phase and increment the line counter.
REQ-035 A vsync rising edge in CAPTURE SHALL set frame_err if the line count != V_ACTIVE.
REQ-036 The same vsync rising edge SHALL increment frame_cnt (mod 256) and clear the line counter.
REQ-037 The same vsync rising edge SHALL move the FSM to ARMED, or to DISABLED if enable=0.
REQ-038 The output SHALL be a one-entry register per channel; a completed pixel SHALL be loaded 1 cycle after its completing pixel-clock event.
REQ-039 m_tvalid/m_tdata/m_tuser/m_tlast SHALL hold stable while m_tvalid=1 and m_tready=0.
REQ-040 A pixel completing while m_tvalid=1 and m_tready=0 SHALL be dropped, SHALL set overflow, and the held entry SHALL be kept.
REQ-041 A pixel completing in the same cycle as a valid&ready handshake SHALL be loaded without overflow.
REQ-042 err_clr=1 SHALL clear all sticky flags; a flag set in the same cycle as err_clr SHALL win.

Reset
REQ-043 rst=1 SHALL put every FSM in DISABLED and clear all synchronizers, counters and rdy flags.
REQ-044 rst=1 SHALL drive all outputs to 0 in the next cycle, including mid-frame, where the partial pixel is discarded.

Verification
REQ-045 Case 1: H_ACTIVE=4, V_ACTIVE=2, BPP=2, one frame of bytes 0x01..0x10 on ch0 with m_tready=1 -> 8 beats 0x0102..0x0F10; tuser on beat 0; tlast on beats 3 and 7; frame_cnt=1; no errors.
REQ-046 Case 2: enable raised mid-frame -> no output until after the next full vsync pulse; the first beat carries tuser=1.
REQ-047 Case 3: frame_sync_en=1, ch1 vsync lagging ch0 by 100 clk -> both m_tuser beats come from the same aligned frame; neither channel captures before the other is rdy.
REQ-048 Case 4: m_tready=0 for 3 pixels -> the first pixel is held, the next 2 are dropped, overflow=1; after err_clr, overflow=0.
REQ-049 Case 5: line of 3 pixels (H_ACTIVE=4), then a frame of 1 line -> line_err=1, frame_err=1, no tlast for the short line.
REQ-050 Case 6: rst asserted mid-line -> all outputs 0 next cycle, FSM in DISABLED; after release with enable=1, capture resumes only after a full vsync pulse.

Source files
------------

// File: rtl/dvp_capture_multi.sv
// dvp_capture_multi: per-channel DVP capture (sync, frame FSM, byte packing) to one-entry stream outputs
module dvp_capture_multi #(
   parameter int NUM_CH = 2,
   parameter int DATA_W = 8,
   parameter int BPP = 2,
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   localparam int PIX_W = DATA_W*BPP
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic                     frame_sync_en,
   input  logic                     err_clr,
   input  logic [NUM_CH-1:0]        vid_pclk,
   input  logic [NUM_CH*DATA_W-1:0] vid_data,
   input  logic [NUM_CH-1:0]        vid_hsync,
   input  logic [NUM_CH-1:0]        vid_vsync,
   output logic [NUM_CH*PIX_W-1:0]  m_tdata,
   output logic [NUM_CH-1:0]        m_tvalid,
   output logic [NUM_CH-1:0]        m_tuser,
   output logic [NUM_CH-1:0]        m_tlast,
   input  logic [NUM_CH-1:0]        m_tready,
   output logic [NUM_CH-1:0]        overflow,
   output logic [NUM_CH-1:0]        line_err,
   output logic [NUM_CH-1:0]        frame_err,
   output logic [NUM_CH*8-1:0]      frame_cnt
);
   localparam int PCW = $clog2(H_ACTIVE+1);
   localparam int LCW = $clog2(V_ACTIVE+2);
   localparam int BCW = BPP > 1 ? $clog2(BPP) : 1;
   typedef enum logic [1:0] {DISABLED, WAIT_VS, ARMED, CAPTURE} state_t;
   logic [NUM_CH-1:0] ok_vec;
   logic all_ok;
   assign all_ok = &ok_vec;
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [2:0] pclk_s, hs_s, vs_s;
      logic [DATA_W-1:0] d_s1, d_s2;
      logic pix_ev, hs_fall, vs_rise, vs_fall, cap, byte_ev, keep, done, go;
      state_t state, state_nxt;
      logic rdy_r, rdy_nxt;
      logic [BCW-1:0] phase;
      logic [PCW-1:0] pix_cnt;
      logic [LCW-1:0] line_cnt;
      logic [PIX_W-1:0] sh, pix, td;
      logic tv, tu, tl, ovf, lerr, ferr, ovf_set, lerr_set, ferr_set;
      logic [7:0] fcnt;
      // data rides two flops like pclk/hsync/vsync so stage 2 of all four is coherent
      always_ff @(posedge clk)
         if (rst) begin
            pclk_s <= '0;
            hs_s <= '0;
            vs_s <= '0;
            d_s1 <= '0;
            d_s2 <= '0;
         end else begin
            pclk_s <= {pclk_s[1:0], vid_pclk[i]};
            hs_s <= {hs_s[1:0], vid_hsync[i]};
            vs_s <= {vs_s[1:0], vid_vsync[i]};
            d_s1 <= vid_data[i*DATA_W +: DATA_W];
            d_s2 <= d_s1;
         end
      assign pix_ev = pclk_s[1] & ~pclk_s[2];
      assign hs_fall = hs_s[2] & ~hs_s[1];
      assign vs_rise = vs_s[1] & ~vs_s[2];
      assign vs_fall = vs_s[2] & ~vs_s[1];
      assign cap = state == CAPTURE;
      assign byte_ev = cap & pix_ev & hs_s[1];
      assign keep = byte_ev & (pix_cnt < PCW'(H_ACTIVE));
      assign done = keep & (phase == BCW'(BPP-1));
      assign pix = PIX_W'({sh, d_s2});
      assign ok_vec[i] = rdy_r & ~vs_rise;
      assign go = ok_vec[i] & (~frame_sync_en | all_ok);
      always_ff @(posedge clk)
         if (rst) begin
            state <= DISABLED;
            rdy_r <= 1'b0;
         end else begin
            state <= state_nxt;
            rdy_r <= rdy_nxt;
         end
      always_comb begin
         state_nxt = state;
         rdy_nxt = 1'b0;
         case (state)
            DISABLED: state_nxt = enable ? WAIT_VS : DISABLED;
            WAIT_VS: state_nxt = !enable ? DISABLED : vs_rise ? ARMED : WAIT_VS;
            ARMED: begin
               state_nxt = !enable ? DISABLED : go ? CAPTURE : ARMED;
               rdy_nxt = enable & ~vs_rise & ~go & (rdy_r | vs_fall);
            end
            default: state_nxt = !vs_rise ? CAPTURE : enable ? ARMED : DISABLED;
         endcase
      end
      always_ff @(posedge clk)
         if (rst || !cap || vs_rise) begin
            phase <= '0;
            pix_cnt <= '0;
            line_cnt <= '0;
            sh <= '0;
         end else if (hs_fall) begin
            phase <= '0;
            pix_cnt <= '0;
            line_cnt <= line_cnt + LCW'(line_cnt <= LCW'(V_ACTIVE));
         end else if (keep) begin
            sh <= pix;
            phase <= done ? '0 : phase + BCW'(1);
            pix_cnt <= pix_cnt + PCW'(done);
         end
      assign ovf_set = done & tv & ~m_tready[i];
      assign lerr_set = (byte_ev & ~keep) | (cap & hs_fall & (pix_cnt != PCW'(H_ACTIVE) || phase != '0));
      assign ferr_set = cap & vs_rise & (line_cnt != LCW'(V_ACTIVE));
      always_ff @(posedge clk)
         if (rst) begin
            tv <= 1'b0;
            td <= '0;
            tu <= 1'b0;
            tl <= 1'b0;
         end else if (done && (!tv || m_tready[i])) begin
            tv <= 1'b1;
            td <= pix;
            tu <= pix_cnt == '0 && line_cnt == '0;
            tl <= pix_cnt == PCW'(H_ACTIVE-1);
         end else if (m_tready[i]) begin
            tv <= 1'b0;
         end
      always_ff @(posedge clk)
         if (rst) begin
            ovf <= 1'b0;
            lerr <= 1'b0;
            ferr <= 1'b0;
            fcnt <= '0;
         end else begin
            ovf <= ovf_set | (ovf & ~err_clr);
            lerr <= lerr_set | (lerr & ~err_clr);
            ferr <= ferr_set | (ferr & ~err_clr);
            fcnt <= fcnt + 8'(cap & vs_rise);
         end
      assign m_tdata[i*PIX_W +: PIX_W] = td;
      assign m_tvalid[i] = tv;
      assign m_tuser[i] = tu;
      assign m_tlast[i] = tl;
      assign overflow[i] = ovf;
      assign line_err[i] = lerr;
      assign frame_err[i] = ferr;
      assign frame_cnt[i*8 +: 8] = fcnt;
   end
endmodule
